vote_session_ctrl: RTL

// - Per-voter ballot sequencer in front of the candidate vote counters. Each vote needs
//   an officer-issued ballot and a qualified, unambiguous button press. The block then

---
 rtl/vote_pkg.sv | 38 +++
 rtl/press_qualifier.sv | 55 +++++
 rtl/vote_session_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/vote_pkg.sv
// Shared types and helpers for the voting-booth ballot sequencer.
package vote_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArmed   = 3'd1,
    StCommit  = 3'd2,
    StLockout = 3'd3,
    StResult  = 3'd4
  } state_t;

  localparam int unsigned NUM_CAND_DFLT = 4;
  // Widest button vector the one-hot helper accepts; callers zero-extend into it.
  localparam int unsigned MAX_CAND      = 32;
  localparam int unsigned MAX_IDX_W     = $clog2(MAX_CAND);

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } onehot_t;

  // valid is high only for exactly one set bit; idx is then that bit's position.
  function automatic onehot_t onehot_check(input logic [MAX_CAND-1:0] v);
    onehot_t     r;
    int unsigned cnt;
    r   = '0;
    cnt = 0;
    for (int i = 0; i < MAX_CAND; i++) begin
      if (v[i]) begin
        cnt++;
        r.idx = MAX_IDX_W'(i);
      end
    end
    r.valid = (cnt == 1);
    return r;
  endfunction

endpackage

// File: rtl/press_qualifier.sv
// Single-press detector: qualifies a button once exactly one bit has been held
// unchanged for HOLD_CYCLES consecutive samples.
module press_qualifier
  import vote_pkg::*;
#(
  parameter int unsigned NUM_CAND    = NUM_CAND_DFLT,
  parameter int unsigned HOLD_CYCLES = 16,
  localparam int unsigned IDX_W      = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [NUM_CAND-1:0] button,
  output logic                qualified,
  output logic [IDX_W-1:0]    idx
);

  localparam int unsigned      HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [NUM_CAND-1:0] prev_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                press_q;
  logic [IDX_W-1:0]    idx_q;
  onehot_t             oh;
  logic                same_single;

  always_comb begin
    oh          = onehot_check(MAX_CAND'(button));
    same_single = oh.valid && (button == prev_q);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prev_q  <= '0;
      hold_q  <= '0;
      press_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      prev_q  <= button;
      press_q <= oh.valid;
      idx_q   <= IDX_W'(oh.idx);
      if (!same_single) begin
        hold_q <= '0;
      end else if (hold_q != HOLD_LAST) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  // press_q guards the HOLD_CYCLES=1 case where hold_q sits at zero with no press.
  assign qualified = press_q && (hold_q == HOLD_LAST);
  assign idx       = idx_q;

endmodule

// File: rtl/vote_session_ctrl.sv
// Per-voter ballot sequencer: issues one single-cycle one-hot vote per officer ballot,
// with post-vote lockout, abandoned-ballot timeout and result-display mode.
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int unsigned NUM_CAND       = NUM_CAND_DFLT,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned LOCK_CYCLES    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode_sw,
  input  logic                ballot_en,
  input  logic [NUM_CAND-1:0] button,
  output logic [NUM_CAND-1:0] vote_valid,
  output logic                mode,
  output logic                ready,
  output logic                vote_cast,
  output logic                timeout,
  output logic [2:0]          state
);

  localparam int unsigned IDX_W  = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q;
  logic [LOCK_W-1:0]  lock_q;
  logic [TO_W-1:0]    tout_q;
  logic               qualified;
  logic [IDX_W-1:0]   idx;

  // Qualifier only runs while armed, so each ballot starts from a clean hold count.
  press_qualifier #(
    .NUM_CAND    (NUM_CAND),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_press (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q != StArmed),
    .button    (button),
    .qualified (qualified),
    .idx       (idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      vote_valid <= '0;
      mode       <= 1'b0;
      ready      <= 1'b0;
      vote_cast  <= 1'b0;
      timeout    <= 1'b0;
      lock_q     <= '0;
      tout_q     <= '0;
    end else begin
      vote_valid <= '0;
      vote_cast  <= 1'b0;
      timeout    <= 1'b0;
      ready      <= 1'b0;
      mode       <= (state_q == StResult);
      unique case (state_q)
        StIdle: begin
          if (mode_sw) begin
            state_q <= StResult;
          end else if (ballot_en) begin
            state_q <= StArmed;
            ready   <= 1'b1;
            tout_q  <= '0;
          end
        end
        StArmed: begin
          // Qualification beats a simultaneous timeout.
          if (qualified) begin
            state_q    <= StCommit;
            vote_valid <= NUM_CAND'(1) << idx;
            vote_cast  <= 1'b1;
          end else if (tout_q == TO_LAST) begin
            state_q <= StIdle;
            timeout <= 1'b1;
          end else if (mode_sw) begin
            state_q <= StIdle;
          end else begin
            ready  <= 1'b1;
            tout_q <= tout_q + 1'b1;
          end
        end
        StCommit: begin
          state_q <= StLockout;
          lock_q  <= '0;
        end
        StLockout: begin
          if (lock_q >= LOCK_LAST && button == '0) begin
            state_q <= StIdle;
          end else if (lock_q != LOCK_LAST) begin
            lock_q <= lock_q + 1'b1;
          end
        end
        StResult: begin
          if (!mode_sw) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign state = state_q;

endmodule
